multdiv_req_sched: RTL and testbench
====================================

Name: multdiv_req_sched

Overview:
- Shares one ibex_multdiv_fast instance (RV32MSingleCycle or RV32MFast) between two requesters, e.g. the core ID stage and a coprocessor/accelerator port.
- Arbitrates requests round-robin, then sequences the unit: en/sel/operator/operands held stable until valid.
- Owns the intermediate-value register file, so the multdiv unit needs no other storage.
- Returns the result to the winning requester over a valid/ready response channel. Supports flush with drain.

Parameters:
- NReq, 2, number of requesters (fixed at 2; round-robin pointer is 1 bit).
- RspHold, 1, 1 = response held until rsp_ready; 0 = single-cycle pulse, no backpressure.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  2  per-requester request valid
- req_ready_o  out  2  per-requester request accept
- req_op_i  in  2x2  per-requester md_op_e (MULL=0, MULH=1, DIV=2, REM=3)
- req_signed_mode_i  in  2x2  bit0 = op_a signed, bit1 = op_b signed
- req_a_i, req_b_i  in  2x32  operands
- flush_i  in  1  discard the in-flight operation's response
- rsp_valid_o  out  2  one-hot response valid
- rsp_ready_i  in  2  response accept
- rsp_result_o  out  32  result (shared bus, qualified by rsp_valid_o)
- md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o  out  1 each  multdiv controls
- md_operator_o  out  2  md_op_e
- md_signed_mode_o  out  2  signed mode to unit
- md_op_a_o, md_op_b_o  out  32  operands to unit
- md_ready_id_o  out  1  drives multdiv_ready_id_i
- md_valid_i  in  1  multdiv valid_o
- md_result_i  in  32  multdiv_result_o
- md_imd_val_d_i  in  2x34  imd_val_d_o
- md_imd_val_we_i  in  2  imd_val_we_o
- md_imd_val_q_o  out  2x34  imd_val_q_i

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, all outputs 0, imd_val regs 0, latched op/operands 0.
- FSM states: IDLE, BUSY, DRAIN, RESP.
- IDLE:
  - req_ready_o[i] = (grant==i); grant = rr_ptr port if it is valid, else the other port.
  - Accept: latch owner, op, signed mode, a, b; go to BUSY next cycle. Nothing accepted outside IDLE.
- BUSY:
  - mult_en = mult_sel = (op is MULL/MULH); div_en = div_sel = (op is DIV/REM).
  - operator, signed_mode and operands are driven from the latched copy and stay stable; md_ready_id_o = 1.
  - On md_valid_i: capture md_result_i and go to RESP; en/sel drop the next cycle.
  - flush_i without md_valid_i: go to DRAIN.
  - flush_i together with md_valid_i: result discarded, go to IDLE, rr_ptr = ~owner.
- DRAIN:
  - Same drive as BUSY; the unit must finish, because its internal FSM only resets on valid.
  - On md_valid_i: go to IDLE, no response, rr_ptr = ~owner.
- RESP:
  - rsp_valid_o[owner] = 1, rsp_result_o = captured result.
  - On rsp_ready_i[owner]: go to IDLE, rr_ptr = ~owner.
  - If RspHold=0: leave after one cycle regardless of rsp_ready_i.
  - flush_i in RESP is ignored (already complete).
- imd_val regs: each index is written with md_imd_val_d_i when its we bit is set, in any state. They are not cleared between operations; the unit initialises them itself.
- Latency:
  - Accept cycle T; BUSY from T+1; rsp_valid at (cycle md_valid_i seen)+1.
  - SingleCycle MULL: rsp_valid at T+3 minimum. DIV: ~37 cycles.
- Result semantics are the unit's: div by zero -> 0xFFFFFFFF, rem by zero -> dividend, signed overflow DIV -> 0x80000000.
- Simultaneous requests: the rr_ptr port wins; the loser waits at most one operation.
- A single requester re-requesting is served back-to-back (grant falls through).
- Reset mid-operation: everything returns to reset values immediately; no response is ever produced for the aborted op.

Decomposition:
- Shared package: md_op_e (from ibex_pkg, reused), the sched_state_e enum, and an md_req_t struct {op, signed_mode, a, b}.
- Natural sub-module: multdiv_rr_arb2 (2-port round-robin grant plus pointer update).
- Optional integration wrapper instantiates ibex_multdiv_fast with the ALU adder model.

Test Plan:
- Port0 MULL a=7, b=6, sm=00 -> rsp_valid_o=01, rsp_result_o=42; rsp_valid_o=01 at T+3 for SingleCycle.
- Port1 DIV a=-100, b=7, sm=11 -> result 0xFFFFFFF2 (-14); REM same operands -> 0xFFFFFFFE (-2).
- Port0 DIV a=5, b=0 -> 0xFFFFFFFF; MULH a=0x80000000, b=2, sm=11 -> 0xFFFFFFFF.
- Both ports valid with rr_ptr=0 -> port0 served first, then port1 without re-arbitration loss; next tie goes to port0 again.
- rsp_ready_i held low 5 cycles in RESP -> result stable, req_ready_o=00, no en asserted; release -> IDLE next cycle.
- flush_i 3 cycles into a DIV -> DRAIN, no rsp_valid; following MULL 3*3 returns 9. rst_ni low mid-DIV -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/multdiv_req_sched_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_req_sched_pkg
// Shared types for the multiply/divide request scheduler:
//   md_op_e        - multdiv operator encoding (same values as ibex_pkg::md_op_e)
//   sched_state_e  - scheduler FSM state, also exported on the debug port
//   md_req_t       - latched copy of an accepted request
// -----------------------------------------------------------------------------
package multdiv_req_sched_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned IMD_W   = 34;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  typedef struct packed {
    md_op_e      op;
    logic [1:0]  signed_mode;
    logic [31:0] a;
    logic [31:0] b;
  } md_req_t;

  function automatic logic op_is_mult(input md_op_e op);
    return (op == MD_OP_MULL) || (op == MD_OP_MULH);
  endfunction

endpackage

// File: rtl/multdiv_req_sched_if.sv
// -----------------------------------------------------------------------------
// multdiv_req_sched_if
// Requester-side bus of the scheduler: two request channels, two response
// channels sharing one result bus, and a flush strobe.
//   master : requester side (drives requests, flush and rsp_ready)
//   slave  : scheduler side (drives req_ready, rsp_valid and rsp_result)
//
// Handshake: a request on port i transfers on a rising clock edge where
// req_valid[i] && req_ready[i]; the requester keeps its fields stable while
// valid is high and not yet accepted. A response transfers on an edge where
// rsp_valid[i] && rsp_ready[i]; rsp_valid is one-hot and rsp_result is only
// meaningful while some rsp_valid bit is set. In pulse mode (no hold) the
// response is offered for exactly one cycle and rsp_ready is ignored.
// -----------------------------------------------------------------------------
interface multdiv_req_sched_if;
  import multdiv_req_sched_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0][1:0]   req_op;
  logic [NUM_REQ-1:0][1:0]   req_signed_mode;
  logic [NUM_REQ-1:0][31:0]  req_a;
  logic [NUM_REQ-1:0][31:0]  req_b;
  logic                      flush;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [31:0]               rsp_result;

  modport master (
    output req_valid, req_op, req_signed_mode, req_a, req_b, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_op, req_signed_mode, req_a, req_b, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );

endinterface

// File: rtl/multdiv_rr_arb2.sv
// -----------------------------------------------------------------------------
// multdiv_rr_arb2
// Two-port round-robin arbiter. The port named by the pointer wins when it is
// requesting, otherwise the grant falls through to the other port.
//   clk_i, rst_ni  : clock, async active-low reset (pointer resets to 0)
//   req_i          : per-port request
//   upd_i          : load the pointer with upd_ptr_i this cycle
//   upd_ptr_i      : new pointer value
//   gnt_o          : one-hot grant (zero when nobody requests)
//   gnt_idx_o      : index of the granted port
//   ptr_o          : current pointer
// -----------------------------------------------------------------------------
module multdiv_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_ptr_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o,
  output logic       ptr_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) ptr_d = upd_ptr_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

  always_comb begin
    gnt_idx_o = req_i[ptr_q] ? ptr_q : ~ptr_q;
    gnt_o     = 2'b00;
    if (|req_i) gnt_o[gnt_idx_o] = 1'b1;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/multdiv_req_sched.sv
// -----------------------------------------------------------------------------
// multdiv_req_sched
// Shares one ibex_multdiv_fast instance between two requesters. Requests are
// arbitrated round-robin, the winning operation is held stable on the md_*
// controls until the unit reports valid, and the result is returned on the
// winner's response channel. The scheduler also owns the unit's intermediate
// value registers.
//   clk_i, rst_ni       : clock, async active-low reset
//   bus_if (slave)      : request/response channels and flush
//   md_*_en_o/_sel_o    : unit enables/selects (asserted in BUSY and DRAIN)
//   md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o : latched operation
//   md_ready_id_o       : drives multdiv_ready_id_i
//   md_valid_i, md_result_i : unit completion and result
//   md_imd_val_d_i/_we_i/_q_o : intermediate value register file
//   dbg_state_o         : current FSM state
// -----------------------------------------------------------------------------
module multdiv_req_sched
  import multdiv_req_sched_pkg::*;
#(
  parameter int unsigned NReq    = NUM_REQ,
  parameter bit          RspHold = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  multdiv_req_sched_if.slave        bus_if,
  output logic                      md_mult_en_o,
  output logic                      md_div_en_o,
  output logic                      md_mult_sel_o,
  output logic                      md_div_sel_o,
  output md_op_e                    md_operator_o,
  output logic [1:0]                md_signed_mode_o,
  output logic [31:0]               md_op_a_o,
  output logic [31:0]               md_op_b_o,
  output logic                      md_ready_id_o,
  input  logic                      md_valid_i,
  input  logic [31:0]               md_result_i,
  input  logic [1:0][IMD_W-1:0]     md_imd_val_d_i,
  input  logic [1:0]                md_imd_val_we_i,
  output logic [1:0][IMD_W-1:0]     md_imd_val_q_o,
  output sched_state_e              dbg_state_o
);

  sched_state_e          state_q, state_d;
  logic                  owner_q, owner_d;
  md_req_t               req_q, req_d;
  logic [31:0]           result_q, result_d;
  logic [1:0][IMD_W-1:0] imd_val_q;

  logic [NReq-1:0] gnt;
  logic            gnt_idx;
  logic            ptr_upd;
  logic            rr_ptr;
  logic [NReq-1:0] req_ready;
  logic [NReq-1:0] rsp_valid;
  logic [31:0]     rsp_result;
  logic            mult_en, div_en, ready_id;
  logic            is_mult;

  multdiv_rr_arb2 u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (bus_if.req_valid),
    .upd_i     (ptr_upd),
    .upd_ptr_i (~owner_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .ptr_o     (rr_ptr)
  );

  assign is_mult = op_is_mult(req_q.op);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    req_d      = req_q;
    result_d   = result_q;
    ptr_upd    = 1'b0;
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_result = '0;
    mult_en    = 1'b0;
    div_en     = 1'b0;
    ready_id   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = gnt;
        if (|gnt) begin
          owner_d           = gnt_idx;
          req_d.op          = md_op_e'(bus_if.req_op[gnt_idx]);
          req_d.signed_mode = bus_if.req_signed_mode[gnt_idx];
          req_d.a           = bus_if.req_a[gnt_idx];
          req_d.b           = bus_if.req_b[gnt_idx];
          state_d           = ST_BUSY;
        end
      end
      ST_BUSY: begin
        mult_en  = is_mult;
        div_en   = ~is_mult;
        ready_id = 1'b1;
        if (md_valid_i) begin
          if (bus_if.flush) begin
            // Completed in the same cycle it was flushed: drop the result.
            state_d = ST_IDLE;
            ptr_upd = 1'b1;
          end else begin
            result_d = md_result_i;
            state_d  = ST_RESP;
          end
        end else if (bus_if.flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Keep driving the unit: its internal FSM only returns to idle once
        // it has produced valid, so abandoning it early would wedge it.
        mult_en  = is_mult;
        div_en   = ~is_mult;
        ready_id = 1'b1;
        if (md_valid_i) begin
          state_d = ST_IDLE;
          ptr_upd = 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        rsp_result         = result_q;
        if (bus_if.rsp_ready[owner_q] || !RspHold) begin
          state_d = ST_IDLE;
          ptr_upd = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      req_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      req_q    <= req_d;
      result_q <= result_d;
    end
  end

  // Intermediate values are written whenever the unit asks, independent of
  // the scheduler state; the unit initialises them itself per operation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      imd_val_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (md_imd_val_we_i[i]) imd_val_q[i] <= md_imd_val_d_i[i];
      end
    end
  end

  assign bus_if.req_ready  = req_ready;
  assign bus_if.rsp_valid  = rsp_valid;
  assign bus_if.rsp_result = rsp_result;

  assign md_mult_en_o     = mult_en;
  assign md_mult_sel_o    = mult_en;
  assign md_div_en_o      = div_en;
  assign md_div_sel_o     = div_en;
  assign md_ready_id_o    = ready_id;
  assign md_operator_o    = req_q.op;
  assign md_signed_mode_o = req_q.signed_mode;
  assign md_op_a_o        = req_q.a;
  assign md_op_b_o        = req_q.b;
  assign md_imd_val_q_o   = imd_val_q;
  assign dbg_state_o      = state_q;

  logic unused_ptr;
  assign unused_ptr = rr_ptr;

endmodule

// File: tb/tb_multdiv_req_sched.sv
module tb_multdiv_req_sched;
  import multdiv_req_sched_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // ---------------- DUT ----------------
  multdiv_req_sched_if bus ();

  logic               md_mult_en, md_div_en, md_mult_sel, md_div_sel;
  logic [1:0]         md_operator, md_signed_mode;
  logic [31:0]        md_op_a, md_op_b, md_result;
  logic               md_ready_id, md_valid;
  logic [1:0][33:0]   md_imd_d, md_imd_q;
  logic [1:0]         md_imd_we;
  sched_state_e       dbg_state;

  multdiv_req_sched #(.NReq(2), .RspHold(1'b1)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .bus_if           (bus),
    .md_mult_en_o     (md_mult_en),
    .md_div_en_o      (md_div_en),
    .md_mult_sel_o    (md_mult_sel),
    .md_div_sel_o     (md_div_sel),
    .md_operator_o    (md_operator),
    .md_signed_mode_o (md_signed_mode),
    .md_op_a_o        (md_op_a),
    .md_op_b_o        (md_op_b),
    .md_ready_id_o    (md_ready_id),
    .md_valid_i       (md_valid),
    .md_result_i      (md_result),
    .md_imd_val_d_i   (md_imd_d),
    .md_imd_val_we_i  (md_imd_we),
    .md_imd_val_q_o   (md_imd_q),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- behavioural multdiv unit ----------------
  // Multiply completes on its 2nd enabled cycle, divide on its 36th.
  function automatic logic [31:0] md_model(input logic [1:0] op, input logic [1:0] sm,
                                           input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] sa, sb;
    logic signed [65:0] p;
    logic signed [31:0] qa, qb;
    sa = {sm[0] & a[31], a};
    sb = {sm[1] & b[31], b};
    p  = sa * sb;
    qa = a;
    qb = b;
    case (op)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      default: begin
        if (b == 32'd0) return (op == 2'd2) ? 32'hFFFF_FFFF : a;
        if (sm == 2'b11) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return (op == 2'd2) ? 32'h8000_0000 : 32'd0;
          return (op == 2'd2) ? 32'(qa / qb) : 32'(qa % qb);
        end
        return (op == 2'd2) ? a / b : a % b;
      end
    endcase
  endfunction

  int   md_cnt;
  logic md_busy;
  int   md_lat;
  assign md_busy   = md_mult_en | md_div_en;
  assign md_lat    = md_div_en ? 36 : 2;
  assign md_valid  = md_busy && (md_cnt == md_lat - 1);
  assign md_result = md_model(md_operator, md_signed_mode, md_op_a, md_op_b);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  md_cnt <= 0;
    else if (md_busy && !md_valid) md_cnt <= md_cnt + 1;
    else                         md_cnt <= 0;
  end

  function automatic logic [178:0] outs_vec();
    return {bus.req_ready, bus.rsp_valid, bus.rsp_result, md_mult_en, md_div_en,
            md_mult_sel, md_div_sel, md_operator, md_signed_mode, md_op_a, md_op_b,
            md_ready_id, md_imd_q, dbg_state};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_req(input int p, input logic [1:0] op, input logic [1:0] sm,
                          input logic [31:0] a, input logic [31:0] b, output int t_acc);
    bit ok;
    ok = 1'b0;
    t_acc = 0;
    @(negedge clk);
    bus.req_op[p] = op;
    bus.req_signed_mode[p] = sm;
    bus.req_a[p] = a;
    bus.req_b[p] = b;
    bus.req_valid[p] = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      if (bus.req_ready[p]) begin ok = 1'b1; t_acc = cyc; end
      else @(negedge clk);
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL accept_timeout port%0d: req_ready stayed 0, wanted 1", p);
    end
    @(posedge clk);
    #1;
    bus.req_valid[p] = 1'b0;
  endtask

  task automatic get_rsp(input int p, input logic [31:0] exp, input int t_acc,
                         input int exp_lat, input string name);
    bit seen;
    logic [31:0] e;
    logic [1:0] exp_v;
    exp_q.push_back(exp);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 2'b00) seen = 1'b1;
    end
    e = exp_q.pop_front();
    exp_v = 2'b00;
    exp_v[p] = 1'b1;
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_timeout: rsp_valid stayed 00, wanted %b", name, exp_v);
    end else begin
      n_vec++;
      if (bus.rsp_valid !== exp_v) begin
        n_err++;
        $display("FAIL %s_valid: got %b, wanted %b", name, bus.rsp_valid, exp_v);
      end
      n_vec++;
      if (bus.rsp_result !== e) begin
        n_err++;
        $display("FAIL %s_result: got %h, wanted %h", name, bus.rsp_result, e);
      end
      if (exp_lat >= 0) begin
        n_vec++;
        if (cyc - t_acc !== exp_lat) begin
          n_err++;
          $display("FAIL %s_latency: got %0d, wanted %0d", name, cyc - t_acc, exp_lat);
        end
      end
      bus.rsp_ready[p] = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready[p] = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if (outs_vec() !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, wanted 0", outs_vec());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_tie();
    @(negedge clk);
    bus.req_op[0] = 2'd0; bus.req_signed_mode[0] = 2'b00; bus.req_a[0] = 32'd2; bus.req_b[0] = 32'd3;
    bus.req_op[1] = 2'd0; bus.req_signed_mode[1] = 2'b00; bus.req_a[1] = 32'd4; bus.req_b[1] = 32'd5;
    bus.req_valid = 2'b11;
    #1;
    n_vec++;
    if (bus.req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL tie_first_grant: got %b, wanted 01", bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    get_rsp(0, 32'd6, 0, -1, "tie_p0");
    n_vec++;
    if (bus.req_ready !== 2'b10) begin
      n_err++;
      $display("FAIL tie_second_grant: got %b, wanted 10", bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid[1] = 1'b0;
    get_rsp(1, 32'd20, 0, -1, "tie_p1");
    bus.req_valid = 2'b11;
    #1;
    n_vec++;
    if (bus.req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL tie_next_grant: got %b, wanted 01", bus.req_ready);
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_mull();
    int t;
    send_req(0, 2'd0, 2'b00, 32'd7, 32'd6, t);
    get_rsp(0, 32'd42, t, 3, "mull_7x6");
  endtask

  task automatic test_div_rem();
    int t;
    send_req(1, 2'd2, 2'b11, 32'hFFFF_FF9C, 32'd7, t);
    get_rsp(1, 32'hFFFF_FFF2, t, 37, "div_m100_7");
    send_req(1, 2'd3, 2'b11, 32'hFFFF_FF9C, 32'd7, t);
    get_rsp(1, 32'hFFFF_FFFE, t, -1, "rem_m100_7");
  endtask

  task automatic test_div_special();
    int t;
    send_req(0, 2'd2, 2'b11, 32'd5, 32'd0, t);
    get_rsp(0, 32'hFFFF_FFFF, t, -1, "div_by_zero");
    send_req(0, 2'd3, 2'b11, 32'd5, 32'd0, t);
    get_rsp(0, 32'd5, t, -1, "rem_by_zero");
    send_req(1, 2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, t);
    get_rsp(1, 32'h8000_0000, t, -1, "div_overflow");
    send_req(0, 2'd1, 2'b11, 32'h8000_0000, 32'd2, t);
    get_rsp(0, 32'hFFFF_FFFF, t, 3, "mulh_min_x2");
  endtask

  task automatic test_back_to_back();
    int t;
    @(negedge clk);
    bus.req_op[0] = 2'd0; bus.req_signed_mode[0] = 2'b00; bus.req_a[0] = 32'd5; bus.req_b[0] = 32'd5;
    bus.req_valid[0] = 1'b1;
    #1;
    t = cyc;
    @(posedge clk);
    get_rsp(0, 32'd25, t, 3, "b2b_first");
    n_vec++;
    if (bus.req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_fallthrough: got %b, wanted 01", bus.req_ready);
    end
    t = cyc;
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    bus.req_a[0] = 32'd99;
    get_rsp(0, 32'd25, t, 3, "b2b_second");
  endtask

  task automatic test_backpressure();
    int t;
    bit seen;
    seen = 1'b0;
    send_req(0, 2'd0, 2'b00, 32'd11, 32'd3, t);
    exp_q.push_back(32'd33);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 2'b00) seen = 1'b1;
    end
    bus.req_op[1] = 2'd0; bus.req_signed_mode[1] = 2'b00; bus.req_a[1] = 32'd1; bus.req_b[1] = 32'd1;
    bus.req_valid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_vec++;
      if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== exp_q[0] || bus.req_ready !== 2'b00 ||
          (md_mult_en | md_div_en) !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle%0d: valid=%b result=%h ready=%b en=%b, wanted 01 %h 00 0",
                 i, bus.rsp_valid, bus.rsp_result, bus.req_ready, md_mult_en | md_div_en, exp_q[0]);
      end
    end
    void'(exp_q.pop_front());
    bus.rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready[0] = 1'b0;
    n_vec++;
    if (dbg_state !== ST_IDLE || bus.req_ready !== 2'b10 || bus.rsp_valid !== 2'b00) begin
      n_err++;
      $display("FAIL hold_release: state=%0d ready=%b valid=%b, wanted 0 10 00",
               dbg_state, bus.req_ready, bus.rsp_valid);
    end
    bus.req_valid[1] = 1'b0;
  endtask

  task automatic test_flush();
    int t;
    bit got, done;
    send_req(0, 2'd2, 2'b11, 32'd1000, 32'd3, t);
    repeat (3) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    n_vec++;
    if (dbg_state !== ST_DRAIN || md_div_en !== 1'b1) begin
      n_err++;
      $display("FAIL flush_drain: state=%0d div_en=%b, wanted 2 1", dbg_state, md_div_en);
    end
    got = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 2'b00) got = 1'b1;
      if (dbg_state === ST_IDLE) done = 1'b1;
    end
    n_vec++;
    if (got || !done) begin
      n_err++;
      $display("FAIL flush_no_rsp: rsp_seen=%b idle=%b, wanted 0 1", got, done);
    end
    send_req(0, 2'd0, 2'b00, 32'd3, 32'd3, t);
    get_rsp(0, 32'd9, t, 3, "mull_after_flush");
    // Flush landing on the completion cycle: result dropped, pointer moves on.
    send_req(0, 2'd0, 2'b00, 32'd8, 32'd8, t);
    @(negedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    n_vec++;
    if (dbg_state !== ST_IDLE || bus.rsp_valid !== 2'b00) begin
      n_err++;
      $display("FAIL flush_on_valid: state=%0d valid=%b, wanted 0 00", dbg_state, bus.rsp_valid);
    end
    bus.req_valid = 2'b11;
    #1;
    n_vec++;
    if (bus.req_ready !== 2'b10) begin
      n_err++;
      $display("FAIL flush_on_valid_ptr: got %b, wanted 10", bus.req_ready);
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_imd();
    @(negedge clk);
    md_imd_d[0] = 34'h3_1234_5678;
    md_imd_d[1] = 34'h0;
    md_imd_we = 2'b01;
    @(posedge clk);
    #1;
    md_imd_we = 2'b00;
    n_vec++;
    if (md_imd_q !== {34'h0, 34'h3_1234_5678}) begin
      n_err++;
      $display("FAIL imd_write0: got %h, wanted %h", md_imd_q, {34'h0, 34'h3_1234_5678});
    end
    md_imd_d[0] = 34'h0;
    md_imd_d[1] = 34'h1_8765_4321;
    md_imd_we = 2'b10;
    @(posedge clk);
    #1;
    md_imd_we = 2'b00;
    n_vec++;
    if (md_imd_q !== {34'h1_8765_4321, 34'h3_1234_5678}) begin
      n_err++;
      $display("FAIL imd_write1: got %h, wanted %h", md_imd_q, {34'h1_8765_4321, 34'h3_1234_5678});
    end
  endtask

  task automatic test_reset_mid();
    int t;
    bit got;
    send_req(1, 2'd2, 2'b00, 32'd77, 32'd5, t);
    md_imd_d[0] = 34'h2_AAAA_5555;
    md_imd_d[1] = 34'h1_5555_AAAA;
    md_imd_we = 2'b11;
    @(posedge clk);
    #1;
    md_imd_we = 2'b00;
    n_vec++;
    if (md_imd_q !== {34'h1_5555_AAAA, 34'h2_AAAA_5555} || dbg_state !== ST_BUSY) begin
      n_err++;
      $display("FAIL imd_busy_write: got %h state=%0d, wanted %h 1",
               md_imd_q, dbg_state, {34'h1_5555_AAAA, 34'h2_AAAA_5555});
    end
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (outs_vec() !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got %h, wanted 0", outs_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 2'b00) got = 1'b1;
    end
    n_vec++;
    if (got) begin
      n_err++;
      $display("FAIL reset_mid_no_rsp: got a response, wanted none");
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    bus.req_valid = 2'b00;
    bus.req_op = '0;
    bus.req_signed_mode = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.flush = 1'b0;
    bus.rsp_ready = 2'b00;
    md_imd_d = '0;
    md_imd_we = 2'b00;

    test_reset();
    test_tie();
    test_mull();
    test_div_rem();
    test_div_special();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_imd();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
